// File: rtl/tribus_arbiter.sv
// Round-robin arbiter driving the S pins of tri_inv bus driver columns.
// Enforces one-hot-or-zero grants, a fixed all-off turnaround gap, and bounded tenure.
module tribus_arbiter #(
  parameter int N          = 4,
  parameter int MAX_HOLD   = 8,
  parameter int TURNAROUND = 1,
  localparam int IW        = (N > 1) ? $clog2(N) : 1
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic [N-1:0]  REQ,
  output logic [N-1:0]  GNT,
  output logic [IW-1:0] OWNER,
  output logic          BUSY,
  output logic          PREEMPT
);

  localparam int HCW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam int TCW = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;
  localparam logic [HCW-1:0] HC_SAT  = HCW'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
  localparam logic [TCW-1:0] TC_INIT = TCW'(TURNAROUND - 1);

  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic [IW-1:0]  owner_q, owner_d;
  logic [IW-1:0]  ptr_q, ptr_d;
  logic [HCW-1:0] hc_q, hc_d;
  logic [TCW-1:0] tc_q, tc_d;
  logic           busy_q, preempt_q, preempt_d;

  logic           win_vld;
  logic [IW-1:0]  win_idx;
  logic           arb, vol_rel, pre_rel;

  // Scan from the highest offset down so the requester nearest PTR wins.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (REQ[(int'(ptr_q) + k) % N]) begin
        win_vld = 1'b1;
        win_idx = IW'((int'(ptr_q) + k) % N);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    hc_d      = hc_q;
    tc_d      = tc_q;
    preempt_d = 1'b0;
    arb       = 1'b0;
    vol_rel   = 1'b0;
    pre_rel   = 1'b0;
    case (state_q)
      IDLE: arb = 1'b1;
      GRANT: begin
        vol_rel = ~REQ[owner_q];
        pre_rel = (MAX_HOLD != 0) && (hc_q == HC_SAT) && (|(REQ & ~gnt_q));
        if (vol_rel || pre_rel) begin
          gnt_d     = '0;
          tc_d      = TC_INIT;
          state_d   = TURN;
          preempt_d = pre_rel & ~vol_rel;
        end else if ((MAX_HOLD != 0) && (hc_q != HC_SAT)) begin
          hc_d = hc_q + 1'b1;
        end
      end
      TURN: begin
        if (tc_q != '0) tc_d = tc_q - 1'b1;
        else            arb  = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // Grants only ever issue from an all-off state, so owners never hand over directly.
    if (arb) begin
      if (win_vld) begin
        gnt_d   = '0;
        gnt_d[win_idx] = 1'b1;
        owner_d = win_idx;
        ptr_d   = IW'((int'(win_idx) + 1) % N);
        hc_d    = '0;
        state_d = GRANT;
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      owner_q   <= '0;
      ptr_q     <= '0;
      hc_q      <= '0;
      tc_q      <= '0;
      busy_q    <= 1'b0;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      hc_q      <= hc_d;
      tc_q      <= tc_d;
      busy_q    <= |gnt_d;
      preempt_q <= preempt_d;
    end
  end

  assign GNT     = gnt_q;
  assign OWNER   = owner_q;
  assign BUSY    = busy_q;
  assign PREEMPT = preempt_q;

endmodule

// File: tb/tb_tribus_arbiter.sv
// Directed bench for tribus_arbiter: default instance plus a TURNAROUND=3 instance.
module tb_tribus_arbiter;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1, RESET3 = 1'b1;
  logic [3:0] REQ = 4'b1111, REQ3 = 4'b0000;
  logic [3:0] GNT, GNT3;
  logic [1:0] OWNER, OWNER3;
  logic       BUSY, BUSY3, PREEMPT, PREEMPT3;
  logic [3:0] prev_gnt = '0, prev_gnt3 = '0;

  int n_cmp = 0;
  int n_bad = 0;

  tribus_arbiter #(.N(4), .MAX_HOLD(8), .TURNAROUND(1)) dut (
    .CLK(CLK), .RESET(RESET), .REQ(REQ), .GNT(GNT),
    .OWNER(OWNER), .BUSY(BUSY), .PREEMPT(PREEMPT));

  tribus_arbiter #(.N(4), .MAX_HOLD(8), .TURNAROUND(3)) dut3 (
    .CLK(CLK), .RESET(RESET3), .REQ(REQ3), .GNT(GNT3),
    .OWNER(OWNER3), .BUSY(BUSY3), .PREEMPT(PREEMPT3));

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    REQ   = 4'b0000;
    tick();
    RESET = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic [3:0] g, input logic [1:0] o,
                         input logic p);
    chk({tag, ".gnt"}, 32'(GNT), 32'(g));
    chk({tag, ".busy"}, 32'(BUSY), 32'(|g));
    chk({tag, ".owner"}, 32'(OWNER), 32'(o));
    chk({tag, ".preempt"}, 32'(PREEMPT), 32'(p));
  endtask

  // Bus-safety invariants on both instances, sampled mid-cycle.
  always @(negedge CLK) begin
    chk("inv.onehot0", 32'($onehot0(GNT)), 32'd1);
    chk("inv.busy", 32'(BUSY), 32'(|GNT));
    if (prev_gnt != 4'b0 && GNT != 4'b0) chk("inv.noswitch", 32'(GNT), 32'(prev_gnt));
    prev_gnt = GNT;
    chk("inv3.onehot0", 32'($onehot0(GNT3)), 32'd1);
    chk("inv3.busy", 32'(BUSY3), 32'(|GNT3));
    if (prev_gnt3 != 4'b0 && GNT3 != 4'b0) chk("inv3.noswitch", 32'(GNT3), 32'(prev_gnt3));
    prev_gnt3 = GNT3;
  end

  initial begin
    // 1: reset with all requesting, and one cycle after release
    tick(); chk_out("t1.rst0", 4'b0000, 2'd0, 1'b0);
    tick(); chk_out("t1.rst1", 4'b0000, 2'd0, 1'b0);
    RESET = 1'b0;
    chk_out("t1.post", 4'b0000, 2'd0, 1'b0);
    tick(); chk_out("t1.first", 4'b0001, 2'd0, 1'b0);
    REQ = 4'b0000;
    tick(); chk_out("t1.drop", 4'b0000, 2'd0, 1'b0);
    tick();

    // 2: single requester for cycles 0-5, then back to IDLE
    do_reset();
    REQ = 4'b0001;
    for (int c = 1; c <= 5; c++) begin
      tick(); chk_out($sformatf("t2.c%0d", c), 4'b0001, 2'd0, 1'b0);
    end
    REQ = 4'b0000;
    tick(); chk_out("t2.c6", 4'b0000, 2'd0, 1'b0);
    tick(); chk_out("t2.c7", 4'b0000, 2'd0, 1'b0);
    REQ = 4'b0100;
    tick(); chk_out("t2.idle_lat", 4'b0100, 2'd2, 1'b0);
    REQ = 4'b0000;
    tick(); tick();

    // 3: round robin with 3-cycle tenures and one-cycle gaps
    do_reset();
    REQ = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      for (int g = 1; g <= 3; g++) begin
        tick(); chk_out($sformatf("t3.o%0d.g%0d", i, g), 4'(1 << i), 2'(i), 1'b0);
      end
      REQ[i] = 1'b0;
      tick(); chk_out($sformatf("t3.gap%0d", i), 4'b0000, 2'(i), 1'b0);
    end
    tick(); chk_out("t3.idle", 4'b0000, 2'd3, 1'b0);

    // 4: preemption after MAX_HOLD cycles
    do_reset();
    REQ = 4'b0001;
    for (int c = 1; c <= 8; c++) begin
      tick(); chk_out($sformatf("t4.c%0d", c), 4'b0001, 2'd0, 1'b0);
      if (c == 3) REQ = 4'b0101;
    end
    tick(); chk_out("t4.c9", 4'b0000, 2'd0, 1'b1);
    tick(); chk_out("t4.c10", 4'b0100, 2'd2, 1'b0);
    REQ = 4'b0000;
    tick(); tick();

    // 4b: voluntary drop coinciding with expiry is not a preemption
    do_reset();
    REQ = 4'b0101;
    for (int c = 1; c <= 8; c++) begin
      tick(); chk_out($sformatf("t4b.c%0d", c), 4'b0001, 2'd0, 1'b0);
    end
    REQ = 4'b0100;
    tick(); chk_out("t4b.c9", 4'b0000, 2'd0, 1'b0);
    tick(); chk_out("t4b.c10", 4'b0100, 2'd2, 1'b0);
    REQ = 4'b0000;
    tick(); tick();

    // 5: lone owner never preempted
    do_reset();
    REQ = 4'b0001;
    for (int c = 1; c <= 20; c++) begin
      tick(); chk_out($sformatf("t5.c%0d", c), 4'b0001, 2'd0, 1'b0);
    end
    REQ = 4'b0000;
    tick(); tick();

    // 5b: TURNAROUND=3 gives three all-off cycles
    RESET3 = 1'b0;
    REQ3   = 4'b0011;
    for (int c = 1; c <= 3; c++) begin
      tick(); chk({"t5b.gnt", $sformatf("%0d", c)}, 32'(GNT3), 32'h1);
    end
    REQ3 = 4'b0010;
    for (int c = 1; c <= 3; c++) begin
      tick();
      chk($sformatf("t5b.gap%0d", c), 32'(GNT3), 32'h0);
      chk($sformatf("t5b.own%0d", c), 32'(OWNER3), 32'h0);
    end
    tick();
    chk("t5b.next", 32'(GNT3), 32'h2);
    chk("t5b.nown", 32'(OWNER3), 32'h1);
    chk("t5b.busy", 32'(BUSY3), 32'h1);
    REQ3 = 4'b0000;

    // 6: reset mid-grant, then fresh arbitration from PTR=0
    do_reset();
    REQ = 4'b1000;
    tick(); chk_out("t6.own3", 4'b1000, 2'd3, 1'b0);
    RESET = 1'b1;
    REQ   = 4'b1010;
    tick(); chk_out("t6.rst", 4'b0000, 2'd0, 1'b0);
    RESET = 1'b0;
    tick(); chk_out("t6.next", 4'b0010, 2'd1, 1'b0);
    REQ = 4'b0000;
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
